// File: rtl/sixteen_bit_divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : sixteen_bit_divider_seq
// Brief    : Iterative unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module sixteen_bit_divider_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;

  logic             w_busy;
  logic             w_done;
  logic             w_load_run;
  logic             w_load_dz;
  logic             w_finish;

  // Partial remainder is kept WIDTH+1 wide so the trial subtract cannot wrap.
  logic [WIDTH:0]   w_partial;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_dvd_next;
  logic             w_last;

  assign w_partial  = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial    = w_partial - {1'b0, r_div};
  assign w_qbit     = ~w_trial[WIDTH];
  assign w_rem_next = w_qbit ? w_trial[WIDTH-1:0] : w_partial[WIDTH-1:0];
  assign w_dvd_next = {r_dvd[WIDTH-2:0], w_qbit};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_load_run   = 1'b0;
    w_load_dz    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        if (start) begin
          if (B == '0) begin
            w_load_dz    = 1'b1;
            w_next_state = S_DONE;
          end else begin
            w_load_run   = 1'b1;
            w_next_state = S_RUN;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_finish     = 1'b1;
          w_next_state = S_DONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // The dividend register doubles as the quotient: bits shift out the top
  // into the partial remainder while quotient bits shift in at the bottom.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dvd <= '0;
      r_div <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (w_load_run) begin
      r_dvd <= A;
      r_div <= B;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_dvd <= w_dvd_next;
      r_rem <= w_rem_next;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q  <= '0;
      r_r  <= '0;
      r_dz <= 1'b0;
    end else if (w_load_dz) begin
      r_q  <= '1;
      r_r  <= A;
      r_dz <= 1'b1;
    end else if (w_finish) begin
      r_q  <= w_dvd_next;
      r_r  <= w_rem_next;
      r_dz <= 1'b0;
    end
  end

  assign busy        = w_busy;
  assign done        = w_done;
  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_sixteen_bit_divider_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sixteen_bit_divider_seq
// Brief    : Scoreboard bench for the sequential divider against a / and % model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sixteen_bit_divider_seq;

  localparam int WIDTH   = 16;
  localparam int LAT_RUN = WIDTH;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  sixteen_bit_divider_seq #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .Q           (Q),
    .R           (R),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
    int               acc;
    int               lat;
  } exp_t;

  exp_t             sb[$];
  int               cyc = 0;
  int               vectors = 0;
  int               miscompares = 0;
  logic [WIDTH-1:0] held_q = '0;
  logic [WIDTH-1:0] held_r = '0;
  logic             held_dz = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // The divider is busy from the cycle after an accepted non-zero-divisor start
  // for exactly WIDTH cycles.
  function automatic bit model_busy();
    foreach (sb[i]) begin
      if (!sb[i].dz && cyc >= sb[i].acc && cyc < sb[i].acc + LAT_RUN) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    exp_t e;
    @(negedge clk);
    #1;
    A     = a;
    B     = b;
    start = s;
    if (s && !model_busy()) begin
      e.a   = a;
      e.b   = b;
      e.acc = cyc + 1;
      if (b == 0) begin
        e.q   = '1;
        e.r   = a;
        e.dz  = 1'b1;
        e.lat = 0;
      end else begin
        e.q   = a / b;
        e.r   = a % b;
        e.dz  = 1'b0;
        e.lat = LAT_RUN;
      end
      sb.push_back(e);
    end
  endtask

  task automatic idle_until_free();
    int guard;
    guard = 0;
    while (model_busy() && guard < 100) begin
      drive('0, '0, 1'b0);
      guard++;
    end
    drive('0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("busy", 32'(busy), 32'(model_busy()));
      if (done) begin
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          vectors++;
          chk("Q", 32'(Q), 32'(e.q));
          chk("R", 32'(R), 32'(e.r));
          chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          if (!e.dz) begin
            chk("QxB+R==A", 32'(Q) * 32'(e.b) + 32'(R), 32'(e.a));
            chk("R<B", 32'(R < e.b), 32'd1);
          end
          held_q  = e.q;
          held_r  = e.r;
          held_dz = e.dz;
        end
      end else begin
        chk("hold_Q", 32'(Q), 32'(held_q));
        chk("hold_R", 32'(R), 32'(held_r));
        chk("hold_dz", 32'(div_by_zero), 32'(held_dz));
      end
    end
  end

  initial begin
    int guard;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_Q", 32'(Q), 32'd0);
    chk("reset_R", 32'(R), 32'd0);
    chk("reset_dz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;

    drive(16'd100, 16'd7, 1'b1);
    drive('0, '0, 1'b0);
    idle_until_free();
    repeat (5) drive('0, '0, 1'b0);

    drive(16'hFFFF, 16'd1, 1'b1);     idle_until_free();
    drive(16'hFFFF, 16'hFFFF, 1'b1);  idle_until_free();
    drive(16'd5, 16'd9, 1'b1);        idle_until_free();
    drive(16'd0, 16'd3, 1'b1);        idle_until_free();

    drive(16'd1234, 16'd0, 1'b1);
    drive('0, '0, 1'b0);
    drive(16'd10, 16'd3, 1'b1);       idle_until_free();

    drive(16'd200, 16'd9, 1'b1);
    for (int i = 1; i <= 18; i++) drive(16'd50, 16'd5, (i == 3) || (i == 10));
    idle_until_free();

    drive(16'd200, 16'd9, 1'b1);
    drive('0, '0, 1'b0);
    repeat (8) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_done", 32'(done), 32'd0);
    chk("async_reset_Q", 32'(Q), 32'd0);
    chk("async_reset_R", 32'(R), 32'd0);
    sb.delete();
    held_q  = '0;
    held_r  = '0;
    held_dz = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    drive(16'd81, 16'd9, 1'b1);       idle_until_free();

    drive(16'd1000, 16'd10, 1'b1);
    repeat (LAT_RUN) drive(16'($urandom), 16'($urandom), 1'b1);
    drive(16'd77, 16'd8, 1'b1);
    drive('0, '0, 1'b0);
    idle_until_free();

    drive(16'd7, 16'd0, 1'b1);
    drive(16'd9, 16'd0, 1'b1);
    drive(16'd9, 16'd4, 1'b1);
    idle_until_free();

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 16'($urandom_range(1, 15));
        2:       rb = 16'hFFFF;
        3:       rb = ra;
        default: rb = 16'($urandom);
      endcase
      drive(ra, rb, 1'b1);
      guard = 0;
      while (model_busy() && guard < 100) begin
        drive(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        guard++;
      end
      if ($urandom_range(0, 1) == 1) drive('0, '0, 1'b0);
    end

    drive('0, '0, 1'b0);
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
